reservation_station: RTL and testbench

Parametrised reservation station for the out-of-order core. It holds RS_SIZE dispatched ops until both source operands are valid, captures operands from the common data bus (CDB) by ROB tag, and issues the oldest ready op to one execution unit over a valid/ready handshake. It sits between the dispatch/rename stage (allocation side) and an execution unit (issue side), and snoops the CDB shared with the ROB.

---
 rtl/ooo_pkg.sv | 52 +++++
 rtl/rs_age_select.sv | 34 +++
 rtl/reservation_station.sv | 172 +++++++++++++++++
 tb/tb_reservation_station.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg
// Shared constants and types for the out-of-order core slice.
//   rs_op    : one source operand {valid, ROB tag, value}
//   rs_entry : one reservation-station slot (busy, operands, dst tag, opcode, age)
//   rs_issue : packet handed to the execution unit
//   op_capture(): CDB snoop on one operand, shared by wakeup and alloc bypass
package ooo_pkg;

  localparam int REG_SIZE  = 64;
  localparam int GPR_COUNT = 32;
  localparam int ROB_SIZE  = 8;
  localparam int TAG_SIZE  = $clog2(ROB_SIZE);
  localparam int OPC_SIZE  = 6;
  // Age field width; covers stations of up to 16 entries.
  localparam int AGE_SIZE  = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_SIZE-1:0] tag;
    logic [REG_SIZE-1:0] value;
  } rs_op;

  typedef struct packed {
    logic                busy;
    rs_op                op1;
    rs_op                op2;
    logic [TAG_SIZE-1:0] dst_tag;
    logic [OPC_SIZE-1:0] opcode;
    logic [AGE_SIZE-1:0] age;
  } rs_entry;

  typedef struct packed {
    logic [REG_SIZE-1:0] op1;
    logic [REG_SIZE-1:0] op2;
    logic [TAG_SIZE-1:0] dst_tag;
    logic [OPC_SIZE-1:0] opcode;
  } rs_issue;

  // A waiting operand whose tag matches the broadcast takes the CDB value.
  function automatic rs_op op_capture(input rs_op op, input logic cdb_valid,
                                      input logic [TAG_SIZE-1:0] cdb_tag,
                                      input logic [REG_SIZE-1:0] cdb_value);
    rs_op r;
    r = op;
    if (!op.valid && cdb_valid && (op.tag == cdb_tag)) begin
      r.valid = 1'b1;
      r.value = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select
// Combinational oldest-ready picker. Ages of busy entries are unique, so at
// most one entry is the minimum among busy && ready ones.
//   i_busy, i_ready : per-entry flags
//   i_age           : per-entry age (0 = oldest)
//   o_onehot        : selected entry
//   o_valid         : some entry is selectable
module rs_age_select
  import ooo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        i_busy,
  input  logic [N-1:0]        i_ready,
  input  logic [AGE_SIZE-1:0] i_age [N],
  output logic [N-1:0]        o_onehot,
  output logic                o_valid
);

  logic [N-1:0] cand;

  always_comb begin
    cand     = i_busy & i_ready;
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && cand[j] && (i_age[j] < i_age[i])) o_onehot[i] = 1'b0;
      end
    end
    o_valid = |cand;
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station
// Holds dispatched ops until both operands are valid, snoops the CDB by ROB
// tag, and issues the oldest ready op over a valid/ready handshake.
// Optional: define RS_DEBUG_EN to add o_debug, a registered copy of all entries.
//   i_clk, i_reset (sync, active-high), i_flush : clock / reset / mispredict flush
//   i_alloc_*  / o_alloc_ready                  : allocation from dispatch
//   i_cdb_*                                     : result broadcast
//   o_issue_* / i_issue_ready                   : issue to execution unit
//   o_count                                     : busy entries (registered)
module reservation_station
  import ooo_pkg::*;
#(
  parameter  int RS_SIZE  = 4,
  parameter  int ROB_SIZE = 8,
  parameter  int REG_SIZE = 64,
  parameter  int OPC_SIZE = 6,
  localparam int TAG_SIZE = $clog2(ROB_SIZE),
  localparam int CNT_W    = $clog2(RS_SIZE + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_alloc_valid,
  output logic                o_alloc_ready,
  input  rs_op                i_alloc_op1,
  input  rs_op                i_alloc_op2,
  input  logic [TAG_SIZE-1:0] i_alloc_dst_tag,
  input  logic [OPC_SIZE-1:0] i_alloc_opcode,
  input  logic                i_cdb_valid,
  input  logic [TAG_SIZE-1:0] i_cdb_tag,
  input  logic [REG_SIZE-1:0] i_cdb_value,
  output logic                o_issue_valid,
  input  logic                i_issue_ready,
  output logic [REG_SIZE-1:0] o_issue_op1,
  output logic [REG_SIZE-1:0] o_issue_op2,
  output logic [TAG_SIZE-1:0] o_issue_dst_tag,
  output logic [OPC_SIZE-1:0] o_issue_opcode,
  output logic [CNT_W-1:0]    o_count
`ifdef RS_DEBUG_EN
  ,
  output rs_entry             o_debug [RS_SIZE]
`endif
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry             ent_q [RS_SIZE];
  rs_entry             ent_d [RS_SIZE];
  logic [CNT_W-1:0]    count_q;
  logic                lock_q;
  logic [IDX_W-1:0]    lock_idx_q;

  logic [RS_SIZE-1:0]  busy_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic [AGE_SIZE-1:0] age_vec [RS_SIZE];
  logic [RS_SIZE-1:0]  pick_onehot;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                free_found;
  logic                issue_fire;
  logic                alloc_fire;
  rs_issue             issue_pkt;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].op1.valid && ent_q[i].op2.valid;
      age_vec[i]   = ent_q[i].age;
    end
  end

  rs_age_select #(.N(RS_SIZE)) u_select (
    .i_busy   (busy_vec),
    .i_ready  (ready_vec),
    .i_age    (age_vec),
    .o_onehot (pick_onehot),
    .o_valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  // Scan downward so the lowest free index wins.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // A stalled packet keeps its entry until accepted, even if an older entry
  // wakes up meanwhile, so the offered packet never changes under the consumer.
  assign sel_idx       = lock_q ? lock_idx_q : pick_idx;
  assign o_issue_valid = !i_flush && !i_reset && (lock_q || pick_valid);
  assign o_alloc_ready = (count_q != CNT_W'(RS_SIZE));
  assign issue_fire    = o_issue_valid && i_issue_ready;
  assign alloc_fire    = i_alloc_valid && o_alloc_ready && !i_flush && free_found;

  always_comb begin
    issue_pkt.op1     = ent_q[sel_idx].op1.value;
    issue_pkt.op2     = ent_q[sel_idx].op2.value;
    issue_pkt.dst_tag = ent_q[sel_idx].dst_tag;
    issue_pkt.opcode  = ent_q[sel_idx].opcode;
  end

  assign o_issue_op1     = issue_pkt.op1;
  assign o_issue_op2     = issue_pkt.op2;
  assign o_issue_dst_tag = issue_pkt.dst_tag;
  assign o_issue_opcode  = issue_pkt.opcode;
  assign o_count         = count_q;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        ent_d[i].op1 = op_capture(ent_q[i].op1, i_cdb_valid, i_cdb_tag, i_cdb_value);
        ent_d[i].op2 = op_capture(ent_q[i].op2, i_cdb_valid, i_cdb_tag, i_cdb_value);
      end
      if (issue_fire) begin
        if (IDX_W'(i) == sel_idx) begin
          ent_d[i].busy = 1'b0;
        end else if (ent_q[i].busy && (ent_q[i].age > ent_q[sel_idx].age)) begin
          ent_d[i].age = ent_q[i].age - 1'b1;
        end
      end
    end
    // The free slot comes from registered busy, so a slot vacated by this
    // cycle's issue is never the target here.
    if (alloc_fire) begin
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].op1     = op_capture(i_alloc_op1, i_cdb_valid, i_cdb_tag, i_cdb_value);
      ent_d[free_idx].op2     = op_capture(i_alloc_op2, i_cdb_valid, i_cdb_tag, i_cdb_value);
      ent_d[free_idx].dst_tag = i_alloc_dst_tag;
      ent_d[free_idx].opcode  = i_alloc_opcode;
      ent_d[free_idx].age     = AGE_SIZE'(count_q) - AGE_SIZE'(issue_fire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      count_q    <= count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
      lock_q     <= o_issue_valid && !i_issue_ready;
      lock_idx_q <= sel_idx;
    end
  end

`ifdef RS_DEBUG_EN
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i_reset) o_debug[i] <= '0;
      else         o_debug[i] <= ent_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
// Directed test of reservation_station: reset, simple issue, CDB wakeup,
// alloc bypass, full/stall/age order, age vs index, flush, reset mid-handshake.
module tb_reservation_station;
  import ooo_pkg::*;

  localparam int RS_N  = 4;
  localparam int CNT_W = $clog2(RS_N + 1);
  localparam int TAG_W = $clog2(8);

  logic               i_clk;
  logic               i_reset;
  logic               i_flush;
  logic               i_alloc_valid;
  logic               o_alloc_ready;
  rs_op               i_alloc_op1;
  rs_op               i_alloc_op2;
  logic [TAG_W-1:0]   i_alloc_dst_tag;
  logic [5:0]         i_alloc_opcode;
  logic               i_cdb_valid;
  logic [TAG_W-1:0]   i_cdb_tag;
  logic [63:0]        i_cdb_value;
  logic               o_issue_valid;
  logic               i_issue_ready;
  logic [63:0]        o_issue_op1;
  logic [63:0]        o_issue_op2;
  logic [TAG_W-1:0]   o_issue_dst_tag;
  logic [5:0]         o_issue_opcode;
  logic [CNT_W-1:0]   o_count;
`ifdef RS_DEBUG_EN
  rs_entry            o_debug [RS_N];
`endif

  int n_cmp = 0;
  int n_err = 0;

  reservation_station #(.RS_SIZE(RS_N), .ROB_SIZE(8), .REG_SIZE(64), .OPC_SIZE(6)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_flush         (i_flush),
    .i_alloc_valid   (i_alloc_valid),
    .o_alloc_ready   (o_alloc_ready),
    .i_alloc_op1     (i_alloc_op1),
    .i_alloc_op2     (i_alloc_op2),
    .i_alloc_dst_tag (i_alloc_dst_tag),
    .i_alloc_opcode  (i_alloc_opcode),
    .i_cdb_valid     (i_cdb_valid),
    .i_cdb_tag       (i_cdb_tag),
    .i_cdb_value     (i_cdb_value),
    .o_issue_valid   (o_issue_valid),
    .i_issue_ready   (i_issue_ready),
    .o_issue_op1     (o_issue_op1),
    .o_issue_op2     (o_issue_op2),
    .o_issue_dst_tag (o_issue_dst_tag),
    .o_issue_opcode  (o_issue_opcode),
    .o_count         (o_count)
`ifdef RS_DEBUG_EN
    ,
    .o_debug         (o_debug)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rs_op mk_op(input logic v, input logic [TAG_W-1:0] t, input logic [63:0] val);
    rs_op r;
    r.valid = v;
    r.tag   = t;
    r.value = val;
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; checks follow at +2.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_alloc(input rs_op a, input rs_op b, input logic [TAG_W-1:0] dst,
                             input logic [5:0] opc);
    i_alloc_valid   = 1'b1;
    i_alloc_op1     = a;
    i_alloc_op2     = b;
    i_alloc_dst_tag = dst;
    i_alloc_opcode  = opc;
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_alloc_valid = 1'b0;
    i_alloc_op1 = '0; i_alloc_op2 = '0; i_alloc_dst_tag = '0; i_alloc_opcode = '0;
    i_cdb_valid = 1'b0; i_cdb_tag = '0; i_cdb_value = '0; i_issue_ready = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    settle();
    chk("reset_count", 64'(o_count), 64'd0);
    chk("reset_alloc_ready", 64'(o_alloc_ready), 64'd1);
    chk("reset_issue_valid", 64'(o_issue_valid), 64'd0);

    // Simple op, both operands ready.
    drive_alloc(mk_op(1, 0, 64'd5), mk_op(1, 0, 64'd7), 3'd3, 6'd1);
    tick();
    i_alloc_valid = 1'b0;
    settle();
    chk("simple_count1", 64'(o_count), 64'd1);
    chk("simple_valid", 64'(o_issue_valid), 64'd1);
    chk("simple_op1", o_issue_op1, 64'd5);
    chk("simple_op2", o_issue_op2, 64'd7);
    chk("simple_dst", 64'(o_issue_dst_tag), 64'd3);
    chk("simple_opc", 64'(o_issue_opcode), 64'd1);
    tick(); settle();
    chk("simple_count0", 64'(o_count), 64'd0);
    chk("simple_empty_valid", 64'(o_issue_valid), 64'd0);

    // Wakeup from CDB two cycles after allocation.
    drive_alloc(mk_op(0, 3'd2, 64'd0), mk_op(1, 0, 64'h11), 3'd5, 6'd2);
    tick();
    i_alloc_valid = 1'b0;
    settle();
    chk("wake_wait0", 64'(o_issue_valid), 64'd0);
    tick(); settle();
    chk("wake_wait1", 64'(o_issue_valid), 64'd0);
    i_cdb_valid = 1'b1; i_cdb_tag = 3'd2; i_cdb_value = 64'h99;
    settle();
    chk("wake_not_same_cycle", 64'(o_issue_valid), 64'd0);
    tick();
    i_cdb_valid = 1'b0;
    settle();
    chk("wake_valid", 64'(o_issue_valid), 64'd1);
    chk("wake_op1", o_issue_op1, 64'h99);
    chk("wake_op2", o_issue_op2, 64'h11);
    chk("wake_dst", 64'(o_issue_dst_tag), 64'd5);
    tick(); settle();
    chk("wake_count0", 64'(o_count), 64'd0);

    // Bypass: CDB matches the operand in its allocation cycle.
    drive_alloc(mk_op(0, 3'd4, 64'd0), mk_op(1, 0, 64'h22), 3'd6, 6'd3);
    i_cdb_valid = 1'b1; i_cdb_tag = 3'd4; i_cdb_value = 64'h44;
    tick();
    i_alloc_valid = 1'b0; i_cdb_valid = 1'b0;
    settle();
    chk("bypass_valid", 64'(o_issue_valid), 64'd1);
    chk("bypass_op1", o_issue_op1, 64'h44);
    chk("bypass_dst", 64'(o_issue_dst_tag), 64'd6);
    tick(); settle();
    chk("bypass_count0", 64'(o_count), 64'd0);

    // Fill with consumer stalled; then drain in age order.
    i_issue_ready = 1'b0;
    for (int k = 0; k < RS_N; k++) begin
      drive_alloc(mk_op(1, 0, 64'(10 * (k + 1))), mk_op(1, 0, 64'(10 * (k + 1) + 1)),
                  TAG_W'(k), 6'(k));
      tick();
    end
    drive_alloc(mk_op(1, 0, 64'h77), mk_op(1, 0, 64'h78), 3'd7, 6'd7);
    settle();
    chk("full_count", 64'(o_count), 64'd4);
    chk("full_alloc_ready", 64'(o_alloc_ready), 64'd0);
    chk("full_issue_dst", 64'(o_issue_dst_tag), 64'd0);
    chk("full_issue_op1", o_issue_op1, 64'd10);
    tick(); settle();
    chk("stall_count", 64'(o_count), 64'd4);
    chk("stall_issue_dst", 64'(o_issue_dst_tag), 64'd0);
    chk("stall_issue_op2", o_issue_op2, 64'd11);
    i_issue_ready = 1'b1;
    tick();
    i_alloc_valid = 1'b0;
    settle();
    chk("full_fire_count", 64'(o_count), 64'd3);
    chk("order_dst1", 64'(o_issue_dst_tag), 64'd1);
    chk("order_op1_1", o_issue_op1, 64'd20);
    tick(); settle();
    chk("order_dst2", 64'(o_issue_dst_tag), 64'd2);
    tick(); settle();
    chk("order_dst3", 64'(o_issue_dst_tag), 64'd3);
    tick(); settle();
    chk("drain_count", 64'(o_count), 64'd0);
    chk("drain_valid", 64'(o_issue_valid), 64'd0);

    // Younger entry lands at a lower index; both wake together.
    i_issue_ready = 1'b0;
    drive_alloc(mk_op(1, 0, 64'h1), mk_op(1, 0, 64'h2), 3'd1, 6'd0);
    tick();
    drive_alloc(mk_op(0, 3'd5, 64'd0), mk_op(1, 0, 64'h3), 3'd2, 6'd0);
    tick();
    i_alloc_valid = 1'b0; i_issue_ready = 1'b1;
    tick(); settle();
    chk("age_count1", 64'(o_count), 64'd1);
    drive_alloc(mk_op(1, 0, 64'h4), mk_op(0, 3'd5, 64'd0), 3'd3, 6'd0);
    tick();
    i_alloc_valid = 1'b0;
    settle();
    chk("age_count2", 64'(o_count), 64'd2);
    chk("age_none_ready", 64'(o_issue_valid), 64'd0);
    i_cdb_valid = 1'b1; i_cdb_tag = 3'd5; i_cdb_value = 64'h55;
    tick();
    i_cdb_valid = 1'b0;
    settle();
    chk("age_first_dst", 64'(o_issue_dst_tag), 64'd2);
    chk("age_first_op1", o_issue_op1, 64'h55);
    tick(); settle();
    chk("age_second_dst", 64'(o_issue_dst_tag), 64'd3);
    chk("age_second_op2", o_issue_op2, 64'h55);
    tick(); settle();
    chk("age_count0", 64'(o_count), 64'd0);

    // Flush a full station while alloc and ready are asserted.
    i_issue_ready = 1'b0;
    for (int k = 0; k < RS_N; k++) begin
      drive_alloc(mk_op(1, 0, 64'(k)), mk_op(1, 0, 64'(k)), TAG_W'(k), 6'd0);
      tick();
    end
    i_flush = 1'b1; i_issue_ready = 1'b1;
    settle();
    chk("flush_issue_valid", 64'(o_issue_valid), 64'd0);
    tick();
    i_flush = 1'b0; i_alloc_valid = 1'b0;
    settle();
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_alloc_ready", 64'(o_alloc_ready), 64'd1);
    chk("flush_after_valid", 64'(o_issue_valid), 64'd0);

    // Reset while a packet is offered.
    i_issue_ready = 1'b0;
    drive_alloc(mk_op(1, 0, 64'hA), mk_op(1, 0, 64'hB), 3'd4, 6'd0);
    tick();
    i_alloc_valid = 1'b0;
    settle();
    chk("rst_hs_offered", 64'(o_issue_valid), 64'd1);
    i_reset = 1'b1; i_issue_ready = 1'b1;
    tick();
    i_reset = 1'b0;
    settle();
    chk("rst_hs_count", 64'(o_count), 64'd0);
    chk("rst_hs_valid", 64'(o_issue_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
